// File: rtl/conv_window_feeder_if.sv
// Frame-stream and convolution-engine handshake bundle for conv_window_feeder.
// master drives frames/engine replies; slave is the feeder itself.
interface conv_window_feeder_if #(
  parameter int N_CH = 5,
  parameter int N_FR = 8,
  parameter int DW   = 16
);
  logic                 i_clear;
  logic                 i_valid;
  logic signed [DW-1:0] i_sample [N_CH];
  logic                 o_ready;
  logic signed [DW-1:0] o_data [N_CH*N_FR];
  logic                 o_start;
  logic                 i_finished;
  logic        [23:0]   i_weights [3];
  logic        [23:0]   o_result [3];
  logic                 o_result_valid;
  logic                 o_error;

  modport master (
    output i_clear, i_valid, i_sample, i_finished, i_weights,
    input  o_ready, o_data, o_start, o_result, o_result_valid, o_error
  );

  modport slave (
    input  i_clear, i_valid, i_sample, i_finished, i_weights,
    output o_ready, o_data, o_start, o_result, o_result_valid, o_error
  );
endinterface

// File: rtl/conv_window_feeder.sv
// Sliding 8x5 sample window feeding the convolution engine; launches one
// convolution per accepted frame once full and latches the three results.
module conv_window_feeder #(
  parameter int N_CH    = 5,
  parameter int N_FR    = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  conv_window_feeder_if.slave  bus
);

  localparam int NW = N_CH * N_FR;
  localparam int FW = $clog2(N_FR + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic signed [DW-1:0] win_q [NW];
  logic signed [DW-1:0] win_d [NW];
  logic [23:0]          result_q [3];
  logic [23:0]          result_d [3];
  logic                 start_q, start_d;
  logic                 rvld_q, rvld_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    tmo_d    = tmo_q;
    win_d    = win_q;
    result_d = result_q;
    start_d  = 1'b0;
    rvld_d   = 1'b0;
    err_d    = err_q;

    // Clear outranks everything, including a same-cycle frame or finish pulse.
    if (bus.i_clear) begin
      state_d = S_FILL;
      fill_d  = '0;
      err_d   = 1'b0;
      for (int i = 0; i < NW; i++) win_d[i] = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (bus.i_valid) begin
            for (int i = 0; i < NW - N_CH; i++) win_d[i] = win_q[i + N_CH];
            for (int c = 0; c < N_CH; c++) win_d[NW - N_CH + c] = bus.i_sample[c];
            if (fill_q != FW'(N_FR)) fill_d = fill_q + 1'b1;
            if (fill_q >= FW'(N_FR - 1)) begin
              state_d = S_START;
              start_d = 1'b1;
            end
          end
        end
        S_START: begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end
        S_WAIT: begin
          if (bus.i_finished) begin
            result_d = bus.i_weights;
            rvld_d   = 1'b1;
            state_d  = S_FILL;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_FILL;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      rvld_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NW; i++) win_q[i] <= '0;
      for (int i = 0; i < 3; i++) result_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      tmo_q    <= tmo_d;
      start_q  <= start_d;
      rvld_q   <= rvld_d;
      err_q    <= err_d;
      win_q    <= win_d;
      result_q <= result_d;
    end
  end

  assign bus.o_ready        = (state_q == S_FILL);
  assign bus.o_data         = win_q;
  assign bus.o_start        = start_q;
  assign bus.o_result       = result_q;
  assign bus.o_result_valid = rvld_q;
  assign bus.o_error        = err_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder with a 4-cycle engine model and a
// result scoreboard.
module tb_conv_window_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic              eng_on = 1'b0;
  int                eng_cnt = 0;
  logic              prev_start = 1'b0;
  logic [2:0][23:0]  sb_q [$];
  logic [2:0][23:0]  exp_w;
  int                s1, s2;

  conv_window_feeder_if #(.N_CH(5), .N_FR(8), .DW(16)) bus ();

  conv_window_feeder #(.N_CH(5), .N_FR(8), .DW(16), .TIMEOUT(15)) dut (
    .i_clk   (clk),
    .i_rst_n (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k);
    bus.i_valid = 1'b1;
    for (int c = 0; c < 5; c++) bus.i_sample[c] = 16'(k + c);
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic set_resp(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    bus.i_weights[0] = a;
    bus.i_weights[1] = b;
    bus.i_weights[2] = c;
  endtask

  function automatic logic data_nonzero();
    logic nz = 1'b0;
    for (int i = 0; i < 40; i++) nz |= (bus.o_data[i] != 16'sd0);
    return nz;
  endfunction

  task automatic chk_row0(input string tag, input int k);
    for (int c = 0; c < 5; c++) chk(tag, 32'(bus.o_data[c]), 32'(k + c));
  endtask

  task automatic chk_results(input string tag, input logic [23:0] a, input logic [23:0] b,
                             input logic [23:0] c);
    chk(tag, {8'h0, bus.o_result[0]}, {8'h0, a});
    chk(tag, {8'h0, bus.o_result[1]}, {8'h0, b});
    chk(tag, {8'h0, bus.o_result[2]}, {8'h0, c});
  endtask

  // Engine: start seen in cycle t+1 gives a one-cycle finish in cycle t+5.
  always begin
    @(posedge clk);
    #1;
    bus.i_finished = 1'b0;
    if (rst) eng_cnt = 0;
    else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) bus.i_finished = 1'b1;
    end else if (bus.o_start && eng_on) eng_cnt = 4;
  end

  // Scoreboard consumer and start-pulse spacing monitor.
  always begin
    @(posedge clk);
    #1;
    if (rst !== 1'b1) begin
      if (bus.o_result_valid) begin
        if (sb_q.size() == 0) chk("unexpected_result_valid", 32'd1, 32'd0);
        else begin
          exp_w = sb_q.pop_front();
          for (int i = 0; i < 3; i++) chk("sb_result", {8'h0, bus.o_result[i]}, {8'h0, exp_w[i]});
        end
      end
      if (bus.o_start) chk("start_back_to_back", {31'b0, prev_start}, 32'd0);
      prev_start = bus.o_start;
    end else prev_start = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_finished = 1'b0;
    for (int c = 0; c < 5; c++) bus.i_sample[c] = '0;
    set_resp(24'h0, 24'h0, 24'h0);

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("rst_start", {31'b0, bus.o_start}, 32'd0);
    chk("rst_rvld", {31'b0, bus.o_result_valid}, 32'd0);
    chk("rst_error", {31'b0, bus.o_error}, 32'd0);
    chk("rst_data_zero", {31'b0, data_nonzero()}, 32'd0);
    chk_results("rst_result", 24'h0, 24'h0, 24'h0);

    // Seven frames: no launch
    for (int k = 0; k < 7; k++) begin
      send(k);
      chk("fill_no_start", {31'b0, bus.o_start}, 32'd0);
      chk("fill_ready", {31'b0, bus.o_ready}, 32'd1);
    end
    for (int c = 0; c < 5; c++) chk("row7_after7", 32'(bus.o_data[35 + c]), 32'(6 + c));

    // Eighth frame launches; engine replies at t+5
    eng_on = 1'b1;
    set_resp(24'h000100, 24'hFFFF00, 24'h7FFFFF);
    sb_q.push_back({24'h7FFFFF, 24'hFFFF00, 24'h000100});
    send(7);
    s1 = cyc;
    chk("first_start", {31'b0, bus.o_start}, 32'd1);
    chk("first_ready_low", {31'b0, bus.o_ready}, 32'd0);
    chk_row0("row0_first", 0);
    bus.i_valid = 1'b1;
    for (int c = 0; c < 5; c++) bus.i_sample[c] = 16'(8 + c);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("busy_ready_low", {31'b0, bus.o_ready}, 32'd0);
      chk("busy_no_rvld", {31'b0, bus.o_result_valid}, 32'd0);
      chk("busy_data_frozen", 32'(bus.o_data[0]), 32'd0);
    end
    tick();
    chk("t6_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("t6_rvld", {31'b0, bus.o_result_valid}, 32'd1);
    chk_results("t6_result", 24'h000100, 24'hFFFF00, 24'h7FFFFF);

    // Held valid: second launch exactly six cycles later
    set_resp(24'h123456, 24'h800000, 24'h000001);
    sb_q.push_back({24'h000001, 24'h800000, 24'h123456});
    tick();
    bus.i_valid = 1'b0;
    s2 = cyc;
    chk("second_start", {31'b0, bus.o_start}, 32'd1);
    chk("start_gap", 32'(s2 - s1), 32'd6);
    chk_row0("row0_second", 1);
    for (int i = 0; i < 5; i++) tick();
    chk("second_rvld", {31'b0, bus.o_result_valid}, 32'd1);
    chk_results("second_result", 24'h123456, 24'h800000, 24'h000001);

    // Silent engine: timeout
    eng_on = 1'b0;
    set_resp(24'hABCDEF, 24'h111111, 24'h222222);
    send(9);
    chk("tmo_start", {31'b0, bus.o_start}, 32'd1);
    chk_row0("row0_third", 2);
    for (int i = 1; i <= 15; i++) tick();
    chk("tmo_error_pre", {31'b0, bus.o_error}, 32'd0);
    chk("tmo_ready_pre", {31'b0, bus.o_ready}, 32'd0);
    tick();
    chk("tmo_error", {31'b0, bus.o_error}, 32'd1);
    chk("tmo_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("tmo_no_rvld", {31'b0, bus.o_result_valid}, 32'd0);
    chk_results("tmo_result_kept", 24'h123456, 24'h800000, 24'h000001);
    tick();
    chk("tmo_error_sticky", {31'b0, bus.o_error}, 32'd1);

    // Clear with a simultaneous frame: frame dropped, fill restarts
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    for (int c = 0; c < 5; c++) bus.i_sample[c] = 16'(50 + c);
    tick();
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    chk("clr_error", {31'b0, bus.o_error}, 32'd0);
    chk("clr_data_zero", {31'b0, data_nonzero()}, 32'd0);
    chk("clr_ready", {31'b0, bus.o_ready}, 32'd1);
    for (int k = 10; k < 17; k++) begin
      send(k);
      chk("refill_no_start", {31'b0, bus.o_start}, 32'd0);
    end
    eng_on = 1'b1;
    send(17);
    chk("refill_start", {31'b0, bus.o_start}, 32'd1);
    chk_row0("row0_refill", 10);

    // Clear collides with the finish pulse: result discarded
    for (int i = 1; i <= 4; i++) tick();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    chk("clrfin_no_rvld", {31'b0, bus.o_result_valid}, 32'd0);
    chk("clrfin_ready", {31'b0, bus.o_ready}, 32'd1);
    chk_results("clrfin_result_kept", 24'h123456, 24'h800000, 24'h000001);
    chk("clrfin_data_zero", {31'b0, data_nonzero()}, 32'd0);
    tick();
    chk("clrfin_no_late_rvld", {31'b0, bus.o_result_valid}, 32'd0);

    // Asynchronous reset while waiting on the engine
    eng_on = 1'b0;
    for (int k = 20; k < 28; k++) send(k);
    chk("arst_start", {31'b0, bus.o_start}, 32'd1);
    tick(); tick();
    chk("arst_waiting", {31'b0, bus.o_ready}, 32'd0);
    rst = 1'b1;
    #2;
    chk("arst_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("arst_start_low", {31'b0, bus.o_start}, 32'd0);
    chk("arst_error", {31'b0, bus.o_error}, 32'd0);
    chk("arst_rvld", {31'b0, bus.o_result_valid}, 32'd0);
    chk("arst_data_zero", {31'b0, data_nonzero()}, 32'd0);
    chk_results("arst_result", 24'h0, 24'h0, 24'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
